// File: rtl/adc_pkg.sv
// Shared constants and the offset-binary to two's-complement conversion
// for the ADC front end.
package adc_pkg;

  localparam int unsigned SAMPLE_W           = 8;
  localparam int unsigned DIV_DEFAULT        = 1000;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 4;

  // Flipping the MSB maps offset-binary to signed: 0x00 -> -128, 0x80 -> 0, 0xFF -> +127.
  function automatic logic [SAMPLE_W-1:0] offset_to_signed(input logic [SAMPLE_W-1:0] i_d);
    return {~i_d[SAMPLE_W-1], i_d[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with a registered head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sample_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic             o_full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_head;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [AW:0]      w_wr_ptr_nxt;
  logic [AW:0]      w_rd_ptr_nxt;
  logic [WIDTH-1:0] w_head_nxt;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A write into a full buffer is accepted only when the head leaves in the same cycle.
  assign w_pop  = i_rd_en && !w_empty;
  assign w_push = i_wr_en && (!w_full || w_pop);

  assign w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
  assign w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

  // Head for the next cycle: the incoming word if it lands at the new read slot.
  always_comb begin
    w_head_nxt = r_head;
    if (w_wr_ptr_nxt != w_rd_ptr_nxt) begin
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = i_wr_data;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt[AW-1:0]];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_head   <= w_head_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_data = r_head;
  assign o_empty   = w_empty;
  assign o_full    = w_full;

endmodule

// File: rtl/adc_front_end.sv
// ADC front end: generates the ADC conversion clock, captures each sample,
// converts it to signed and buffers it for the downstream filter.
module adc_front_end
  import adc_pkg::*;
#(
  parameter int unsigned DIV        = DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] data_8bit_in,
  output logic                adc_clk,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                overrun,
  input  logic                overrun_clr
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] r_div_cnt;
  logic          r_adc_clk;
  logic          r_overrun;

  logic [CW-1:0] w_div_cnt_nxt;
  logic          w_capture;
  logic          w_pop;
  logic          w_empty;
  logic          w_full;
  logic          w_drop;

  // Capture in the last high cycle, just before the ADC clock falls.
  assign w_capture     = (r_div_cnt == CW'(DIV - 1));
  assign w_div_cnt_nxt = w_capture ? '0 : r_div_cnt + CW'(1);

  assign w_pop  = !w_empty && sample_ready;
  assign w_drop = w_capture && w_full && !w_pop;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_div_cnt <= '0;
      r_adc_clk <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_div_cnt <= w_div_cnt_nxt;
      r_adc_clk <= (w_div_cnt_nxt >= CW'(DIV / 2));
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  sample_fifo #(
    .WIDTH(SAMPLE_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk    (sys_clk),
    .i_rst    (rst),
    .i_wr_en  (w_capture),
    .i_wr_data(offset_to_signed(data_8bit_in)),
    .i_rd_en  (sample_ready),
    .o_rd_data(sample_out),
    .o_empty  (w_empty),
    .o_full   (w_full)
  );

  assign adc_clk      = r_adc_clk;
  assign sample_valid = !w_empty;
  assign overrun      = r_overrun;

endmodule
